// File: rtl/instr_fetch_stage.sv
// Fetch front end: owns the PC, issues in-order word fetches under a credit
// limit, buffers returned words and hands {instr, instr_pc} to decode.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] pending_q, pending_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_word_q [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire, stale_resp, push, pop;
  logic [31:0]   redirect_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    redirect_target = redirect_pc & ~32'h3;
    credit_used     = {1'b0, pending_q} + {1'b0, count_q};
    imem_req_valid  = rst_n & ~redirect_valid & (credit_used < (CW+1)'(DEPTH));
    imem_req_addr   = fetch_pc_q;
    req_fire        = imem_req_valid & imem_req_ready;
    stale_resp      = imem_resp_valid & (drop_q != '0);
    push            = imem_resp_valid & (drop_q == '0) & ~redirect_valid;
    instr_valid     = (count_q != '0);
    pop             = instr_valid & instr_ready & ~redirect_valid;
    instr           = instr_valid ? fifo_word_q[rd_ptr_q] : NOP;
    instr_pc        = instr_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    pending_d  = pending_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_d     = drop_q - CW'(stale_resp);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    // Non-stale responses come back in request order from one sequential run,
    // so the PC of the next good word is just a counter from the last target.
    if (push) resp_pc_d = resp_pc_q + 32'd4;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      // Every request still outstanding after this edge becomes stale.
      drop_d     = pending_q - CW'(imem_resp_valid);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      pending_q  <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push && !pop)
        assert (count_q != CW'(DEPTH)) else $error("instruction buffer overflow");
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_word_q[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench: memory model + queue-based reference, scoreboard monitor
// compares request channel and decode-side outputs every cycle.
module tb_instr_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;

  instr_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

  out_t        out_q[$];   // requests accepted by memory, not yet answered
  exp_t        exp_q[$];   // words that decode must see, in order
  logic [31:0] exp_fetch_pc = RESET_PC;
  int          epoch = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  bit          rst_knob = 1'b0;
  int          p_ready = 100, p_irdy = 100, p_redir = 0;
  int          lat_min = 1, lat_max = 1;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, expv);
    end
  endfunction

  // Drive one cycle of stimulus at the falling edge, then advance the
  // reference model by what happens at the following rising edge.
  task automatic step(input int n);
    out_t h;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      rst_n          = rst_knob;
      imem_req_ready = ($urandom_range(99) < p_ready);
      instr_ready    = ($urandom_range(99) < p_irdy);
      if (!rst_n) begin
        imem_resp_valid = $urandom_range(1) == 1;
        imem_resp_data  = $urandom;
        redirect_valid  = 1'b0;
      end else begin
        if (out_q.size() > 0 && out_q[0].due <= cyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(out_q[0].addr);
        end else begin
          imem_resp_valid = 1'b0;
          imem_resp_data  = $urandom;
        end
        if (force_redir) begin
          redirect_valid = 1'b1;
          redirect_pc    = force_tgt;
        end else begin
          redirect_valid = ($urandom_range(99) < p_redir);
          redirect_pc    = $urandom;
          if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        end
      end
      #2;
      if (!rst_n) begin
        out_q.delete();
        exp_q.delete();
        exp_fetch_pc = RESET_PC;
      end else begin
        if (imem_resp_valid && out_q.size() > 0) begin
          h = out_q.pop_front();
          if (!redirect_valid && h.epoch == epoch)
            exp_q.push_back('{pc: h.addr, word: mem_word(h.addr)});
        end
        if (imem_req_valid && imem_req_ready) begin
          out_q.push_back('{addr: exp_fetch_pc, epoch: epoch,
                            due: cyc + $urandom_range(lat_max, lat_min)});
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (redirect_valid) begin
          epoch++;
          exp_q.delete();
          exp_fetch_pc = redirect_pc & ~32'h3;
        end
      end
    end
  endtask

  // Scoreboard monitor: compares between edges, pops on each decode handshake.
  always @(negedge clk) begin
    logic exp_rv;
    #1;
    if (chk_en) begin
      exp_rv = rst_n && !redirect_valid && (out_q.size() + exp_q.size() < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (imem_req_valid && imem_req_ready && exp_rv)
        check("req_addr", imem_req_addr, exp_fetch_pc);
      check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("instr", instr, exp_q[0].word);
        check("instr_pc", instr_pc, exp_q[0].pc);
        if (instr_ready && !redirect_valid && rst_n) void'(exp_q.pop_front());
      end else begin
        check("idle_instr", instr, 32'h0000_0013);
        check("idle_pc", instr_pc, 32'h0);
      end
    end
  end

  initial begin
    rst_knob = 1'b0;
    step(2);
    chk_en = 1'b1;
    step(1);

    // Streaming from reset: always-ready memory, 1-cycle latency.
    rst_knob = 1'b1;
    step(20);

    // Decode stalls: buffer fills to DEPTH, then drains in order.
    p_irdy = 0;   step(10);
    p_irdy = 100; step(10);

    // Redirect with two requests outstanding.
    lat_min = 2; lat_max = 2;
    step(6);
    force_redir = 1'b1; force_tgt = 32'h0000_0103; step(1);
    force_redir = 1'b0; step(15);

    // Redirect colliding with a response and a pop, then back-to-back redirects.
    lat_min = 1; lat_max = 1;
    step(6);
    force_redir = 1'b1; force_tgt = 32'h0000_0200; step(1);
    force_redir = 1'b0; step(8);
    force_redir = 1'b1; force_tgt = 32'h0000_0300; step(1);
    force_tgt = 32'h0000_0402; step(1);
    force_redir = 1'b0; step(10);

    // Address wrap at the top of the address space.
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFF4; step(1);
    force_redir = 1'b0; step(12);

    // Random traffic.
    p_ready = 70; p_irdy = 70; p_redir = 5; lat_min = 1; lat_max = 4;
    step(3000);

    // Reset mid-stream with a full buffer.
    p_ready = 100; p_irdy = 0; p_redir = 0; lat_min = 1; lat_max = 1;
    step(8);
    rst_knob = 1'b0; step(2);
    rst_knob = 1'b1; p_irdy = 100; step(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
